// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS ALU / multiply-divide unit.
// Operation codes and the mul/div sequencer states.
package mips_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULT  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIV   = 4'b1010,
    OP_DIVU  = 4'b1011
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/mips_alu_comb.sv
// Single-cycle ALU: AND/OR/ADD/SUB/SLT with signed overflow.
// Purely combinational; the top registers its outputs.
module mips_alu_comb
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] low;
  logic [WIDTH:0]   full;
  logic             v;

  always_comb begin
    sub  = (op_i == OP_SUB) || (op_i == OP_SLT);
    bx   = sub ? ~b_i : b_i;
    // low[W-1] is the carry into the MSB
    low  = {1'b0, a_i[WIDTH-2:0]}
         + {1'b0, bx[WIDTH-2:0]}
         + {{(WIDTH-1){1'b0}}, sub};
    full = {1'b0, a_i}
         + {1'b0, bx}
         + {{WIDTH{1'b0}}, sub};
    v    = low[WIDTH-1] ^ full[WIDTH];

    result_o = a_i & b_i;
    ovf_o    = 1'b0;
    case (op_i)
      OP_OR: begin
        result_o = a_i | b_i;
      end
      OP_ADD, OP_SUB: begin
        result_o = full[WIDTH-1:0];
        ovf_o    = v;
      end
      OP_SLT: begin
        result_o = {{(WIDTH-1){1'b0}},
                    full[WIDTH-1] ^ v};
      end
      default: begin
        result_o = a_i & b_i;
      end
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/mips_alu_muldiv.sv
// MIPS ALU with iterative shift-add multiplier and restoring divider.
// Mul/div run on magnitudes for WIDTH cycles; signs are applied in FIX.
module mips_alu_muldiv
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] alu_res;
  logic             alu_z;
  logic             alu_v;

  mips_alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .result_o(alu_res),
    .zero_o  (alu_z),
    .ovf_o   (alu_v)
  );

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_q;
  logic             aneg_q;
  logic             divz_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic             is_md;
  logic             sgn;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] q_d;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  always_comb begin
    is_md = is_muldiv(op);
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    sa    = sgn & a[WIDTH-1];
    sb    = sgn & b[WIDTH-1];
    ma    = sa ? -a : a;
    mb    = sb ? -b : b;

    // Multiply: acc holds the high half, q_q the multiplier
    addend = q_q[0] ? {1'b0, m_q} : '0;
    add_s  = acc_q + addend;
    // Divide: acc holds the partial remainder, q_q dividend/quotient
    sh     = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    ge     = (sh >= {1'b0, m_q});

    if (is_div_q) begin
      acc_d = ge ? (sh - {1'b0, m_q}) : sh;
      q_d   = {q_q[WIDTH-2:0], ge};
    end else begin
      acc_d = {1'b0, add_s[WIDTH:1]};
      q_d   = {add_s[0], q_q[WIDTH-1:1]};
    end

    prod_u = {acc_q[WIDTH-1:0], q_q};
    prod   = neg_q ? -prod_u : prod_u;
    rem    = acc_q[WIDTH-1:0];

    if (!is_div_q) begin
      hi_d = prod[2*WIDTH-1:WIDTH];
      lo_d = prod[WIDTH-1:0];
    end else if (divz_q) begin
      hi_d = a_q;
      lo_d = '1;
    end else begin
      hi_d = aneg_q ? -rem : rem;
      lo_d = neg_q ? -q_q : q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      aneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            dz_q <= 1'b0;
            if (is_md) begin
              state_q  <= S_RUN;
              cnt_q    <= '0;
              is_div_q <= op[1];
              neg_q    <= sa ^ sb;
              aneg_q   <= sa;
              divz_q   <= op[1] & (b == '0);
              a_q      <= a;
              acc_q    <= '0;
              m_q      <= op[1] ? mb : ma;
              q_q      <= op[1] ? ma : mb;
            end else begin
              result_q <= alu_res;
              zero_q   <= alu_z;
              ovf_q    <= alu_v;
              done_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dz_q    <= divz_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign ovf      = ovf_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed vector bench for mips_alu_muldiv at WIDTH=32.
// Table of hand-computed vectors plus mid-op start and reset sequences.
module tb_mips_alu_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  mips_alu_muldiv #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .zero    (zero),
    .ovf     (ovf),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        v;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vt[18];
  int   total;
  int   fails;

  function automatic void chk(input string nm,
                              input logic [63:0] got,
                              input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  task automatic run(input logic [3:0] o,
                     input logic [31:0] xa,
                     input logic [31:0] xb,
                     output int cyc);
    op    = o;
    a     = xa;
    b     = xb;
    start = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) break;
    end
  endtask

  logic [31:0] mres;
  logic        mz;
  logic        mv;
  logic [31:0] mhi;
  logic [31:0] mlo;
  int          cyc;
  int          ndone;
  logic        md;

  initial begin
    vt[0]  = '{4'h2, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
    vt[1]  = '{4'h6, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[2]  = '{4'h7, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[3]  = '{4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{4'h1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[5]  = '{4'h6, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
    vt[6]  = '{4'h7, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[7]  = '{4'h3, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[8]  = '{4'h2, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[9]  = '{4'h7, 32'h80000000, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vt[10] = '{4'h8, 32'hFFFFFFFD, 32'h7,        32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[11] = '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h1,        1'b0};
    vt[12] = '{4'hB, 32'd100,      32'd7,        32'h0, 1'b0, 1'b0, 32'd2,        32'd14,       1'b0};
    vt[13] = '{4'hA, 32'hFFFFFFF9, 32'h2,        32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[14] = '{4'hA, 32'd9,        32'h0,        32'h0, 1'b0, 1'b0, 32'd9,        32'hFFFFFFFF, 1'b1};
    vt[15] = '{4'h2, 32'h1,        32'h2,        32'h3, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
    vt[16] = '{4'hA, 32'h7,        32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 32'h1,        32'hFFFFFFFD, 1'b0};
    vt[17] = '{4'h8, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h0, 1'b0, 1'b0, 32'h0,        32'h14,       1'b0};

    total = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 4'h0;
    a     = '0;
    b     = '0;

    repeat (2) @(negedge clk);
    chk("reset_state",
        {result, zero, ovf, busy, done, div_zero, 26'h0},
        64'h0);
    chk("reset_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;
    mres = '0; mz = 1'b0; mv = 1'b0; mhi = '0; mlo = '0;

    for (int i = 0; i < 18; i++) begin
      md = (vt[i].op[3:2] == 2'b10);
      run(vt[i].op, vt[i].a, vt[i].b, cyc);
      chk($sformatf("v%0d_latency", i), cyc, md ? 34 : 1);
      chk($sformatf("v%0d_div_zero", i), div_zero, vt[i].dz);
      if (md) begin
        chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
        chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
        chk($sformatf("v%0d_alu_hold", i),
            {result, zero, ovf}, {mres, mz, mv});
        mhi = vt[i].hi;
        mlo = vt[i].lo;
      end else begin
        chk($sformatf("v%0d_result", i), result, vt[i].res);
        chk($sformatf("v%0d_zero", i), zero, vt[i].z);
        chk($sformatf("v%0d_ovf", i), ovf, vt[i].v);
        chk($sformatf("v%0d_hilo_hold", i), {hi, lo}, {mhi, mlo});
        mres = vt[i].res;
        mz   = vt[i].z;
        mv   = vt[i].v;
      end
    end

    // start pulsed while a multiply is running must be ignored
    op = 4'h8; a = 32'd6; b = 32'd7; start = 1'b1;
    cyc = 0;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    repeat (4) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_busy", busy, 1'b1);
    op = 4'h8; a = 32'd100; b = 32'd100; start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) break;
    end
    chk("mid_latency", cyc, 34);
    chk("mid_hilo", {hi, lo}, 64'd42);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mid_no_second_op", ndone, 0);

    // reset in the middle of a multiply discards it
    op = 4'h8; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_outs", {result, zero, ovf, done, div_zero}, 36'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_hilo_after", {hi, lo}, 64'h0);

    // start accepted on the first edge after reset release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(4'h2, 32'd2, 32'd3, cyc);
    chk("post_rst_latency", cyc, 1);
    chk("post_rst_result", result, 32'd5);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/mips_alu_muldiv.md
MIPS_ALU_MULDIV -- requirements
Module: mips_alu_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal values are even numbers 8..64.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  one-cycle operation request; sampled only in IDLE.
REQ-005 Port: op  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU; other codes are treated as AND.
REQ-006 Port: a, b  input  WIDTH  operands, captured on the accepted start.
REQ-007 Port: result  output  WIDTH  registered single-cycle ALU result.
REQ-008 Port: zero  output  1  registered; 1 when result is 0.
REQ-009 Port: ovf  output  1  registered signed overflow; ADD/SUB only, else 0.
REQ-010 Port: hi, lo  output  WIDTH  mul/div result registers.
REQ-011 Port: busy  output  1  high while a mul/div operation is in progress.
REQ-012 Port: done  output  1  one-cycle pulse when an operation's outputs are valid.
REQ-013 Port: div_zero  output  1  registered; set by DIV/DIVU with b=0, cleared by the next accepted start.

Function
REQ-014 ALU ops (op[3]=0) SHALL update result/zero/ovf at the first edge after an accepted start and pulse done that same cycle; hi/lo are unchanged.
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf = carry into MSB XOR carry out of MSB.
REQ-016 SLT SHALL give result 1 when a<b signed (sign of a-b corrected by overflow), else 0.
REQ-017 FSM states: IDLE, RUN, FIX; IDLE->RUN on start with op[3]=1; RUN->FIX after exactly WIDTH iterations; FIX->IDLE unconditionally.
REQ-018 MULT/MULTU SHALL use iterative shift-add, one bit per RUN cycle; {hi,lo} = full 2*WIDTH product.
REQ-019 DIV/DIVU SHALL use restoring division, one quotient bit per RUN cycle; lo = quotient, hi = remainder.
REQ-020 Signed ops SHALL operate on magnitudes; FIX applies signs: product negated if signs differ, quotient negated if signs differ, remainder takes dividend's sign.
REQ-021 Divide by zero SHALL still take full latency and give lo = all ones, hi = a, div_zero = 1.
REQ-022 hi/lo SHALL be written only in FIX; done pulses in the cycle after FIX; start-to-done latency = WIDTH+2 cycles.
REQ-023 busy SHALL be 1 in RUN and FIX; start while busy is ignored with no side effects.
REQ-024 result/zero/ovf SHALL hold their values across mul/div operations.
REQ-025 A start accepted in the cycle done pulses SHALL be honoured normally (back-to-back operation).

Reset
REQ-026 On rst_n low, all outputs and internal registers SHALL clear to 0 immediately and the FSM SHALL enter IDLE, including mid-operation; the partial mul/div result is discarded.
REQ-027 The first start is accepted at the first rising edge after rst_n deasserts.

Structure
REQ-028 Package mips_alu_pkg SHALL hold the op encoding enum and the FSM state enum.
REQ-029 Single-cycle logic SHALL be the sub-module mips_alu_comb (WIDTH-parametrised, combinational a/b/op -> result/zero/ovf), instantiated once.

Verification (WIDTH=32)
REQ-030 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, ovf=1, zero=0, done 1 cycle after start.
REQ-031 SUB a=5 b=5 -> result 0, zero=1; SLT a=0xFFFFFFFF b=1 -> result 1.
REQ-032 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done 34 cycles after start; MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.
REQ-033 DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 DIV a=9 b=0 -> div_zero=1, lo=0xFFFFFFFF, hi=9; next ADD clears div_zero.
REQ-035 start with MULT pulsed mid-MULT -> ignored, first result intact; rst_n low mid-MULT -> busy=0, hi=lo=0, no done.
